// File: rtl/arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : arb_mux
// Purpose  : Registered N-channel mux with valid/ready on every input and on
//            the output. Channel is picked by an explicit select (mode=0) or
//            by a fair round-robin arbiter (mode=1). One register stage
//            keeps mux depth out of the downstream critical path.
// Revision : 1.0 - initial release
// ============================================================================
module arb_mux #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan
);

   // Pointer restarts at the last channel so the first round-robin scan
   // begins at channel 0.
   localparam logic [SEL_W-1:0] c_ptr_reset = SEL_W'(CHANNELS - 1);

   logic [SEL_W-1:0] r_ptr;        // last channel granted in round-robin mode
   logic             w_load_en;    // output register free to take a new beat
   logic             w_has_cand;   // a candidate channel exists this cycle
   logic [SEL_W-1:0] w_cand;       // index of the candidate channel
   logic             w_xfer;       // handshake completes on the candidate
   logic [WIDTH-1:0] w_cand_data;  // data of the candidate channel
   int               w_best_dist;  // scan distance of best valid channel so far
   int               w_dist;       // scan distance of the channel under test

   assign w_load_en = !out_valid || out_ready;

   // Candidate selection: explicit select, or nearest valid channel after ptr.
   always_comb begin
      w_has_cand  = 1'b0;
      w_cand      = '0;
      w_best_dist = CHANNELS;
      w_dist      = 0;
      if (!mode) begin
         if (int'(sel) < CHANNELS) begin
            w_has_cand = 1'b1;
            w_cand     = sel;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            // Distance 0 is the channel right after ptr; wraps modulo CHANNELS.
            w_dist = i + CHANNELS - 1 - int'(r_ptr);
            if (w_dist >= CHANNELS) begin
               w_dist = w_dist - CHANNELS;
            end
            if (in_valid[i] && (w_dist < w_best_dist)) begin
               w_best_dist = w_dist;
               w_has_cand  = 1'b1;
               w_cand      = SEL_W'(i);
            end
         end
      end
   end

   // One-hot ready toward the candidate only, gated by output availability.
   always_comb begin
      in_ready = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         in_ready[i] = w_has_cand && w_load_en && (w_cand == SEL_W'(i));
      end
   end

   // Data steering for the candidate channel.
   always_comb begin
      w_cand_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (w_cand == SEL_W'(i)) begin
            w_cand_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign w_xfer = |(in_valid & in_ready);

   // Output register and arbitration pointer: load, drain or hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         r_ptr     <= c_ptr_reset;
      end else begin
         if (w_xfer) begin
            out_valid <= 1'b1;
            out_data  <= w_cand_data;
            out_chan  <= w_cand;
            if (mode) begin
               r_ptr <= w_cand;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
